// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - shared constants, FSM encodings and helpers for the HDR tone-mapper
package hdr_pkg;

    localparam int LE_W        = 8;
    localparam int FP          = 4;
    localparam int SCALE_W     = 16;
    localparam int SCALE_FRAC  = 8;
    localparam int MIN_SPAN    = 1;
    localparam int DIV_NUM     = 65280;
    localparam int RESET_SCALE = 256;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    function automatic logic [LE_W-1:0] min3(input logic [LE_W-1:0] a,
                                             input logic [LE_W-1:0] b,
                                             input logic [LE_W-1:0] c);
        logic [LE_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [LE_W-1:0] max3(input logic [LE_W-1:0] a,
                                             input logic [LE_W-1:0] b,
                                             input logic [LE_W-1:0] c);
        logic [LE_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/seq_div.sv
// rtl/seq_div.sv - restoring divider, one quotient bit per cycle, start wins over abort
module seq_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    import hdr_pkg::*;

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W:0]    rem_sh;
    logic [W:0]    rem_sub;
    logic          take;

    always_comb begin
        // Remainder never exceeds the divisor, so one extra bit covers the shift.
        rem_sh  = {rem_q, quo_q[W-1]};
        rem_sub = rem_sh - {1'b0, div_q};
        take    = (rem_sh >= {1'b0, div_q});

        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (abort) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d = W'(take ? rem_sub : rem_sh);
            quo_d = {quo_q[W-2:0], take};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/hdr_tonemap.sv
// rtl/hdr_tonemap.sv - log-radiance to RGB565 linear normalisation over the previous frame's range
module hdr_tonemap #(
    parameter int LE_W     = hdr_pkg::LE_W,
    parameter int SCALE_W  = hdr_pkg::SCALE_W,
    parameter int MIN_SPAN = hdr_pkg::MIN_SPAN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    le_valid,
    input  logic [LE_W-1:0]         lE_red,
    input  logic [LE_W-1:0]         lE_green,
    input  logic [LE_W-1:0]         lE_blue,
    input  logic                    frame_end,
    output logic [hdr_pkg::R_W-1:0] red_out,
    output logic [hdr_pkg::G_W-1:0] green_out,
    output logic [hdr_pkg::B_W-1:0] blue_out,
    output logic                    pix_valid,
    output logic                    scale_busy
);
    import hdr_pkg::*;

    localparam int PW = LE_W + SCALE_W;
    localparam int HW = PW - SCALE_FRAC;

    // Returns the saturated LE_W-bit normalised value of d * scale.
    function automatic logic [LE_W-1:0] tone(input logic [LE_W-1:0]    d,
                                             input logic [SCALE_W-1:0] s);
        logic [PW-1:0] p;
        logic [HW-1:0] hi;
        p  = PW'(d) * PW'(s);
        hi = HW'(p >> SCALE_FRAC);
        return (|hi[HW-1:LE_W]) ? {LE_W{1'b1}} : hi[LE_W-1:0];
    endfunction

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [LE_W-1:0]    run_min_q, run_min_d;
    logic [LE_W-1:0]    run_max_q, run_max_d;
    logic [LE_W-1:0]    lat_min_q, lat_min_d;
    logic [LE_W-1:0]    act_min_q, act_min_d;
    logic [SCALE_W-1:0] act_scale_q, act_scale_d;

    logic [LE_W-1:0]    pix_min, pix_max, eff_min, eff_max, raw_span, span;
    logic               empty, fe_go, load;
    logic [SCALE_W-1:0] div_quo;
    logic               div_done;

    always_comb begin
        pix_min  = min3(lE_red, lE_green, lE_blue);
        pix_max  = max3(lE_red, lE_green, lE_blue);
        eff_min  = (le_valid && pix_min < run_min_q) ? pix_min : run_min_q;
        eff_max  = (le_valid && pix_max > run_max_q) ? pix_max : run_max_q;
        empty    = (eff_max < eff_min);
        raw_span = eff_max - eff_min;
        span     = (raw_span < LE_W'(MIN_SPAN)) ? LE_W'(MIN_SPAN) : raw_span;
        fe_go    = frame_end && !empty;

        run_min_d = frame_end ? {LE_W{1'b1}} : eff_min;
        run_max_d = frame_end ? '0 : eff_max;
        lat_min_d = fe_go ? eff_min : lat_min_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 4'd15) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                load    = div_done;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new non-empty frame boundary discards any division in flight, including a pending LOAD.
        if (fe_go) begin
            state_d = ST_DIV;
            cnt_d   = '0;
            load    = 1'b0;
        end
        act_min_d   = load ? lat_min_q : act_min_q;
        act_scale_d = load ? div_quo : act_scale_q;
    end

    seq_div #(.W(SCALE_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (fe_go),
        .abort    (fe_go && state_q != ST_IDLE),
        .dividend (SCALE_W'(DIV_NUM)),
        .divisor  (SCALE_W'(span)),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_min_q   <= {LE_W{1'b1}};
            run_max_q   <= '0;
            lat_min_q   <= '0;
            act_min_q   <= '0;
            act_scale_q <= SCALE_W'(RESET_SCALE);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            lat_min_q   <= lat_min_d;
            act_min_q   <= act_min_d;
            act_scale_q <= act_scale_d;
        end
    end

    logic [LE_W-1:0]    s1_r_q, s1_g_q, s1_b_q;
    logic [SCALE_W-1:0] s1_scale_q;
    logic               s1_valid_q;
    logic [R_W-1:0]     red_q;
    logic [G_W-1:0]     green_q;
    logic [B_W-1:0]     blue_q;
    logic               pix_valid_q;

    // Offset and scale are sampled together so a pixel never straddles a LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            s1_scale_q  <= '0;
            s1_valid_q  <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= le_valid;
            pix_valid_q <= s1_valid_q;
            if (le_valid) begin
                s1_r_q     <= (lE_red   >= act_min_q) ? lE_red   - act_min_q : '0;
                s1_g_q     <= (lE_green >= act_min_q) ? lE_green - act_min_q : '0;
                s1_b_q     <= (lE_blue  >= act_min_q) ? lE_blue  - act_min_q : '0;
                s1_scale_q <= act_scale_q;
            end
            if (s1_valid_q) begin
                red_q   <= R_W'(tone(s1_r_q, s1_scale_q) >> (LE_W - R_W));
                green_q <= G_W'(tone(s1_g_q, s1_scale_q) >> (LE_W - G_W));
                blue_q  <= B_W'(tone(s1_b_q, s1_scale_q) >> (LE_W - B_W));
            end
        end
    end

    assign red_out    = red_q;
    assign green_out  = green_q;
    assign blue_out   = blue_q;
    assign pix_valid  = pix_valid_q;
    assign scale_busy = (state_q == ST_DIV) || (state_q == ST_LOAD);

endmodule

// File: tb/tb_hdr_tonemap.sv
// tb/tb_hdr_tonemap.sv - directed self-checking bench for hdr_tonemap
module tb_hdr_tonemap;

    logic       clk;
    logic       rst_n;
    logic       le_valid;
    logic [7:0] lE_red, lE_green, lE_blue;
    logic       frame_end;
    logic [4:0] red_out;
    logic [5:0] green_out;
    logic [4:0] blue_out;
    logic       pix_valid;
    logic       scale_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_busy;

    hdr_tonemap dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .le_valid   (le_valid),
        .lE_red     (lE_red),
        .lE_green   (lE_green),
        .lE_blue    (lE_blue),
        .frame_end  (frame_end),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out),
        .pix_valid  (pix_valid),
        .scale_busy (scale_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic fe);
        le_valid  = v;
        lE_red    = r;
        lE_green  = g;
        lE_blue   = b;
        frame_end = fe;
        @(negedge clk);
        le_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic px_check(input string tag, input logic [7:0] e,
                            input int er, input int eg, input int eb);
        drive(1'b1, e, e, e, 1'b0);
        @(negedge clk);
        chk({tag, "_pv"}, int'(pix_valid), 1);
        chk({tag, "_r"},  int'(red_out),   er);
        chk({tag, "_g"},  int'(green_out), eg);
        chk({tag, "_b"},  int'(blue_out),  eb);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (scale_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        le_valid = 1'b0;
        frame_end = 1'b0;
        lE_red = '0;
        lE_green = '0;
        lE_blue = '0;
        repeat (3) @(negedge clk);
        chk("rst_pv",   int'(pix_valid),  0);
        chk("rst_r",    int'(red_out),    0);
        chk("rst_g",    int'(green_out),  0);
        chk("rst_b",    int'(blue_out),   0);
        chk("rst_busy", int'(scale_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: identity mapping out of reset
        px_check("t1", 8'h80, 16, 32, 16);
        chk("t1_busy", int'(scale_busy), 0);

        // close the frame holding the test-1 pixel
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_idle(n_busy);
        chk("t1_close_len", n_busy, 17);

        // 2: frame 0x20..0x60 -> scale 1020
        drive(1'b1, 8'h20, 8'h20, 8'h20, 1'b0);
        drive(1'b1, 8'h40, 8'h40, 8'h40, 1'b0);
        drive(1'b1, 8'h60, 8'h60, 8'h60, 1'b1);
        chk("t2_busy_now", int'(scale_busy), 1);
        wait_idle(n_busy);
        chk("t2_busy_len", n_busy, 17);
        px_check("t2_60", 8'h60, 31, 63, 31);
        px_check("t2_40", 8'h40, 15, 31, 15);

        // 3: below min and saturation
        px_check("t3_10", 8'h10, 0, 0, 0);
        px_check("t3_f0", 8'hF0, 31, 63, 31);

        // frame 0x10..0xF0: span 224, scale 291, min 0x10
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_idle(n_busy);
        chk("t3_close_len", n_busy, 17);
        px_check("t3_90", 8'h90, 18, 36, 18);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_idle(n_busy);
        chk("t3_close2_len", n_busy, 17);

        // 4: flat frame, span clamped to 1
        drive(1'b1, 8'h50, 8'h50, 8'h50, 1'b0);
        drive(1'b1, 8'h50, 8'h50, 8'h50, 1'b0);
        drive(1'b1, 8'h50, 8'h50, 8'h50, 1'b1);
        wait_idle(n_busy);
        chk("t4_busy_len", n_busy, 17);
        px_check("t4_50", 8'h50, 0, 0, 0);
        px_check("t4_51", 8'h51, 31, 63, 31);

        // 5: frame A (span 128) aborted by frame B (min 0x51, span 64)
        drive(1'b1, 8'h00, 8'h40, 8'h80, 1'b1);
        px_check("t5_old", 8'h51, 31, 63, 31);
        chk("t5_busy_mid", int'(scale_busy), 1);
        repeat (2) @(negedge clk);
        drive(1'b1, 8'h91, 8'h91, 8'h91, 1'b1);
        wait_idle(n_busy);
        chk("t5_busy_len", n_busy, 17);
        px_check("t5_71", 8'h71, 15, 31, 15);

        // 6: async reset during a division with pixels in flight
        drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        le_valid = 1'b1;
        lE_red = 8'h71;
        lE_green = 8'h71;
        lE_blue = 8'h71;
        @(negedge clk);
        @(negedge clk);
        chk("t6_pre_pv",   int'(pix_valid),  1);
        chk("t6_pre_r",    int'(red_out),    15);
        chk("t6_pre_busy", int'(scale_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pv",   int'(pix_valid),  0);
        chk("t6_rst_r",    int'(red_out),    0);
        chk("t6_rst_g",    int'(green_out),  0);
        chk("t6_rst_b",    int'(blue_out),   0);
        chk("t6_rst_busy", int'(scale_busy), 0);
        le_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_busy", int'(scale_busy), 0);
        px_check("t6_80", 8'h80, 16, 32, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hdr_tonemap.md
Name: hdr_tonemap

Overview:
Display-side counterpart of the HDR merge stage. It consumes the per-pixel log-radiance stream (lE_red/lE_green/lE_blue, 8-bit, FP=4) and maps it back to an RGB565 display pixel. Mapping is a linear normalisation of lE over the previous frame's [min, max] range. Per-frame statistics are gathered on the fly, and a sequential divider recomputes the scale factor at each frame boundary.

Parameters:
LE_W, 8, log-radiance input width per channel
SCALE_W, 16, scale-factor width (unsigned, 8 fractional bits)
MIN_SPAN, 1, lower bound applied to (max - min) before division

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
le_valid  in  1  lE inputs valid this cycle (driven by hdr_done)
lE_red  in  LE_W  red log radiance
lE_green  in  LE_W  green log radiance
lE_blue  in  LE_W  blue log radiance
frame_end  in  1  single-cycle pulse marking the last pixel of a frame
red_out  out  5  tone-mapped red
green_out  out  6  tone-mapped green
blue_out  out  5  tone-mapped blue
pix_valid  out  1  outputs valid
scale_busy  out  1  divider running; the active scale is from the previous frame

Behaviour:
- Reset (async, rst_n=0):
  - red_out/green_out/blue_out = 0, pix_valid = 0, scale_busy = 0.
  - Active min = 0, active scale = 256 (identity: n = lE).
  - Running min = 255, running max = 0. FSM = IDLE.
- Statistics:
  - On each le_valid cycle, running min/max are updated with the minimum and maximum of the three channels.
- Frame boundary (frame_end=1):
  - The latched span includes that cycle's pixel if le_valid=1.
  - latched_min = running min, span = max(running max - running min, MIN_SPAN).
  - Running min/max then reset to 255/0 in the same cycle.
  - Empty frame (running max < running min): no division, active min/scale unchanged.
- FSM:
  - IDLE -> DIV on a non-empty frame_end. Start the divider with 65280 / span (16-bit restoring, 1 quotient bit per cycle).
  - DIV -> LOAD after 16 cycles.
  - LOAD: active min <= latched_min, active scale <= quotient; -> IDLE.
  - scale_busy = 1 in DIV and LOAD, i.e. 17 cycles starting the cycle after frame_end.
  - frame_end during DIV or LOAD aborts the current division and restarts DIV with the new span. The old active values stay until the new LOAD.
- Datapath, 2-cycle latency (le_valid at cycle t -> pix_valid at t+2):
  - Stage 1: per channel d = (lE >= active_min) ? lE - active_min : 0. The active scale is captured alongside d.
  - Stage 2: p = d * scale (24 bits); n = p[23:16] != 0 ? 255 : p[15:8].
  - Outputs: red = n[7:3], green = n[7:2], blue = n[7:3].
  - pix_valid = le_valid delayed 2. Outputs hold their value when pix_valid = 0.
- Update visibility: a new active min/scale written in LOAD at cycle u applies to pixels with le_valid at cycle >= u+1. A pixel never mixes an old min with a new scale.
- Back-to-back le_valid is supported at full rate. There is no backpressure.

Decomposition:
- hdr_pkg: LE_W, FP=4, SCALE_W, DIV_NUM=65280, RESET_SCALE=256, RGB565 channel widths, FSM state enum (IDLE, DIV, LOAD).
- Sub-module seq_div: 16-bit restoring divider with ports start, abort, dividend, divisor, quotient, done. It is instantiated once.

Test Plan:
1. Reset -> le_valid with lE=0x80 on all channels -> two cycles later red=16, green=32, blue=16, pix_valid=1; scale_busy=0.
2. Frame with min 0x20, max 0x60, then frame_end -> scale_busy high 17 cycles, active scale=1020.
   - Next lE=0x60 -> red=31, green=63.
   - lE=0x40 -> red=15, green=31.
3. After test 2: lE=0x10 (below min) -> all outputs 0. lE=0xF0 -> n saturates to 255 -> red=31, green=63, blue=31.
4. Flat frame, all pixels 0x50 -> span clamped to 1, scale=65280. lE=0x50 -> 0; lE=0x51 -> red=31.
5. Second frame_end 5 cycles into DIV -> division restarts; scale_busy stays high until 17 cycles after the second pulse. Only the second frame's scale is loaded; pixels during busy use the old scale.
6. rst_n asserted mid-DIV and mid-stream -> outputs/pix_valid drop to 0 immediately (asynchronously). After release, lE=0x80 reproduces the identity result of test 1.
